// File: rtl/alu_flags_reg.sv
// Registered N/V/Z/C status flags with Z-chaining, software write/clear and a saturating overflow counter.
// Optional sticky flag accumulator enabled by defining FLAGS_STICKY_EN.
module alu_flags_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] result,
   input  logic             carry_in,
   input  logic             overflow_in,
   input  logic [3:0]       op_sel,
   input  logic             chain_in,
   input  logic             flag_clr,
   input  logic             flag_wr,
   input  logic [3:0]       flag_wdata,
   output logic             carry_flag,
   output logic             zero_flag,
   output logic             overflow_flag,
   output logic             negative_flag,
   output logic [3:0]       sticky_flags,
   output logic [CNT_W-1:0] ovf_count,
   output logic             valid_out
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_MUL = 4'b0001;
   localparam logic [3:0] OP_DIV = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b1000;
   localparam logic [3:0] OP_SHL = 4'b1100;
   localparam logic [3:0] OP_SHR = 4'b1101;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
      return (&val) ? val : val + CNT_W'(1);
   endfunction

   logic n_p0, z_p0, c_p0, v_p0;
   logic clear_p0, upd_p0;

   // Stage p0: next-state flags from the live inputs
   always_comb begin
      n_p0 = result[WIDTH-1];
      z_p0 = (result == '0) & ~overflow_in & (~chain_in | zero_flag);
      c_p0 = 1'b0;
      v_p0 = 1'b0;
      case (op_sel)
         OP_ADD, OP_SUB: begin
            c_p0 = carry_in;
            v_p0 = overflow_in;
         end
         OP_MUL: begin
            c_p0 = carry_in;
            v_p0 = carry_in;
         end
         OP_DIV: begin
            c_p0 = 1'b0;
            v_p0 = 1'b0;
         end
         OP_SHL, OP_SHR: begin
            c_p0 = carry_in;
            v_p0 = 1'b0;
         end
         default: begin
            c_p0 = 1'b0;
            v_p0 = 1'b0;
         end
      endcase
   end

   assign clear_p0 = rst | flag_clr;
   assign upd_p0   = valid_in & ~flag_wr;

   // Stage p1: registered flags, counter and valid
   always_ff @(posedge clk) begin
      if (clear_p0) begin
         {negative_flag, overflow_flag, zero_flag, carry_flag} <= 4'b0000;
         ovf_count <= '0;
         valid_out <= 1'b0;
      end else if (flag_wr) begin
         {negative_flag, overflow_flag, zero_flag, carry_flag} <= flag_wdata;
         valid_out <= 1'b0;
      end else if (valid_in) begin
         {negative_flag, overflow_flag, zero_flag, carry_flag} <= {n_p0, v_p0, z_p0, c_p0};
         valid_out <= 1'b1;
         if (v_p0)
            ovf_count <= sat_inc(ovf_count);
      end else begin
         valid_out <= 1'b0;
      end
   end

`ifdef FLAGS_STICKY_EN
   always_ff @(posedge clk) begin
      if (clear_p0)
         sticky_flags <= 4'b0000;
      else if (upd_p0)
         sticky_flags <= sticky_flags | {n_p0, v_p0, z_p0, c_p0};
   end
`else
   assign sticky_flags = 4'b0000;
   logic unused_p0;
   assign unused_p0 = upd_p0;
`endif

endmodule

// File: tb/tb_alu_flags_reg.sv
// Scoreboard bench for alu_flags_reg (WIDTH=8, CNT_W=2); works with or without FLAGS_STICKY_EN.
module tb_alu_flags_reg;

   logic       clk = 1'b0;
   logic       rst, valid_in, carry_in, overflow_in, chain_in, flag_clr, flag_wr;
   logic [7:0] result;
   logic [3:0] op_sel, flag_wdata;
   logic       carry_flag, zero_flag, overflow_flag, negative_flag, valid_out;
   logic [3:0] sticky_flags;
   logic [1:0] ovf_count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] f;
      logic [3:0] s;
      logic [1:0] c;
      logic       v;
   } exp_t;
   exp_t sb[$];

   logic [3:0] m_flags = 4'b0000;
   logic [3:0] m_sticky = 4'b0000;
   logic [1:0] m_cnt = 2'd0;

   alu_flags_reg #(.WIDTH(8), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .result(result),
      .carry_in(carry_in), .overflow_in(overflow_in), .op_sel(op_sel),
      .chain_in(chain_in), .flag_clr(flag_clr), .flag_wr(flag_wr),
      .flag_wdata(flag_wdata), .carry_flag(carry_flag), .zero_flag(zero_flag),
      .overflow_flag(overflow_flag), .negative_flag(negative_flag),
      .sticky_flags(sticky_flags), .ovf_count(ovf_count), .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] dut_flags();
      return {negative_flag, overflow_flag, zero_flag, carry_flag};
   endfunction

   // One clock: drive inputs, push the model's expectation, compare after the edge.
   task automatic step(input logic r, input logic clr, input logic wr, input logic [3:0] wd,
                       input logic vin, input logic [3:0] op, input logic [7:0] res,
                       input logic cin, input logic ovf, input logic ch);
      logic n, z, c, v, vo;
      exp_t e, got;
      n = res[7];
      z = (res == 8'h00) && !ovf && (!ch || m_flags[1]);
      case (op)
         4'b0000, 4'b1000: begin c = cin;  v = ovf;  end
         4'b0001:          begin c = cin;  v = cin;  end
         4'b1100, 4'b1101: begin c = cin;  v = 1'b0; end
         default:          begin c = 1'b0; v = 1'b0; end
      endcase
      vo = 1'b0;
      if (r || clr) begin
         m_flags = 4'b0000; m_sticky = 4'b0000; m_cnt = 2'd0;
      end else if (wr) begin
         m_flags = wd;
      end else if (vin) begin
         m_flags = {n, v, z, c};
         m_sticky = m_sticky | {n, v, z, c};
         if (v && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
         vo = 1'b1;
      end
      e.f = m_flags;
`ifdef FLAGS_STICKY_EN
      e.s = m_sticky;
`else
      e.s = 4'b0000;
`endif
      e.c = m_cnt;
      e.v = vo;
      sb.push_back(e);

      rst = r; flag_clr = clr; flag_wr = wr; flag_wdata = wd; valid_in = vin;
      op_sel = op; result = res; carry_in = cin; overflow_in = ovf; chain_in = ch;
      @(posedge clk);
      #1;
      rst = 1'b0; flag_clr = 1'b0; flag_wr = 1'b0; valid_in = 1'b0; chain_in = 1'b0;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 8'd0, 8'd1);
      end else begin
         got = sb.pop_front();
         chk("flags", {4'b0, dut_flags()}, {4'b0, got.f});
         chk("sticky", {4'b0, sticky_flags}, {4'b0, got.s});
         chk("ovf_count", {6'b0, ovf_count}, {6'b0, got.c});
         chk("valid_out", {7'b0, valid_out}, {7'b0, got.v});
      end
   endtask

   task automatic op_step(input logic [3:0] op, input logic [7:0] res, input logic cin,
                          input logic ovf, input logic ch);
      step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, op, res, cin, ovf, ch);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; valid_in = 1'b0; result = 8'h00; carry_in = 1'b0; overflow_in = 1'b0;
      op_sel = 4'b0000; chain_in = 1'b0; flag_clr = 1'b0; flag_wr = 1'b0; flag_wdata = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_flags", {4'b0, dut_flags()}, 8'h00);
      chk("reset_sticky", {4'b0, sticky_flags}, 8'h00);
      chk("reset_cnt", {6'b0, ovf_count}, 8'h00);
      chk("reset_valid", {7'b0, valid_out}, 8'h00);
      rst = 1'b0;

      // add with zero result and carry
      op_step(4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("add_nvzc", {4'b0, dut_flags()}, 8'b0011);
      idle();
      chk("idle_hold", {4'b0, dut_flags()}, 8'b0011);

      // sub overflow, saturating counter
      repeat (4) op_step(4'b1000, 8'h80, 1'b0, 1'b1, 1'b0);
      chk("sub_nvzc", {4'b0, dut_flags()}, 8'b1100);
      chk("cnt_sat", {6'b0, ovf_count}, 8'd3);

      // Z chaining
      op_step(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
      op_step(4'b0000, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("chain_z1", {7'b0, zero_flag}, 8'd1);
      op_step(4'b0000, 8'h01, 1'b0, 1'b0, 1'b0);
      op_step(4'b0000, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("chain_z0", {7'b0, zero_flag}, 8'd0);

      // mul / div / shifts / logic
      op_step(4'b0001, 8'h10, 1'b1, 1'b0, 1'b0);
      chk("mul_nvzc", {4'b0, dut_flags()}, 8'b0101);
      op_step(4'b0010, 8'h10, 1'b1, 1'b0, 1'b0);
      chk("div_nvzc", {4'b0, dut_flags()}, 8'b0000);
      op_step(4'b1100, 8'h10, 1'b1, 1'b0, 1'b0);
      chk("shl_nvzc", {4'b0, dut_flags()}, 8'b0001);
      op_step(4'b1101, 8'hF0, 1'b1, 1'b1, 1'b0);
      op_step(4'b0100, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("logic_nvzc", {4'b0, dut_flags()}, 8'b0000);

      // software write beats valid_in, then clear beats write
      step(1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 4'b1000, 8'h80, 1'b0, 1'b1, 1'b0);
      chk("wr_nvzc", {4'b0, dut_flags()}, 8'b1010);
      chk("wr_cnt", {6'b0, ovf_count}, 8'd3);
      step(1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("clr_nvzc", {4'b0, dut_flags()}, 8'b0000);
      chk("clr_cnt", {6'b0, ovf_count}, 8'd0);

      // sticky accumulation
      op_step(4'b0000, 8'h01, 1'b1, 1'b0, 1'b0);
      op_step(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef FLAGS_STICKY_EN
      chk("sticky_acc", {4'b0, sticky_flags}, 8'b0011);
`else
      chk("sticky_off", {4'b0, sticky_flags}, 8'b0000);
`endif
      step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
      op_step(4'b0001, 8'h80, 1'b1, 1'b0, 1'b0);

      // reset mid-chain, then chain_in with cleared zero_flag
      op_step(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("rst_mid_flags", {4'b0, dut_flags()}, 8'h00);
      chk("rst_mid_sticky", {4'b0, sticky_flags}, 8'h00);
      op_step(4'b0000, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("chain_after_rst", {7'b0, zero_flag}, 8'd0);
      op_step(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
